// File: rtl/frame_counter.sv
// Sample pass-through with one cycle of latency that tags each sample with index, frame and frame flags.
// Optional FRAME_COUNTER_WRAP_EN: restart at index 0 after the last sample instead of stopping in DONE.
module frame_counter #(
    parameter int INPUTLENGTH  = 14,
    parameter int OUTPUTLENGTH = 14,
    parameter int TOTAL_DATA   = 15104,
    parameter int FRAME_LEN    = 256,
    parameter int NUM_W        = $clog2(TOTAL_DATA),
    parameter int POS_W        = $clog2(FRAME_LEN),
    parameter int FRM_W        = ($clog2((TOTAL_DATA + FRAME_LEN - 1) / FRAME_LEN) > 0)
                               ? $clog2((TOTAL_DATA + FRAME_LEN - 1) / FRAME_LEN) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    di_en,
    input  logic [INPUTLENGTH-1:0]  data_i,
    output logic                    do_en,
    output logic [OUTPUTLENGTH-1:0] data_o,
    output logic [NUM_W-1:0]        num,
    output logic [POS_W-1:0]        pos,
    output logic [FRM_W-1:0]        frame,
    output logic                    sof,
    output logic                    eof,
    output logic                    last,
    output logic                    done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [NUM_W-1:0] num_cnt, num_cnt_nx;
    logic [POS_W-1:0] pos_cnt, pos_cnt_nx;
    logic [FRM_W-1:0] frm_cnt, frm_cnt_nx;
    logic             accept;
    logic             at_last;
    logic             at_frame_end;
    logic             done_nx;

    assign accept       = di_en && (state != DONE) && !clr;
    assign at_last      = (num_cnt == NUM_W'(TOTAL_DATA - 1));
    assign at_frame_end = (pos_cnt == POS_W'(FRAME_LEN - 1));

    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_nx   = state;
        num_cnt_nx = num_cnt;
        pos_cnt_nx = pos_cnt;
        frm_cnt_nx = frm_cnt;
        done_nx    = 1'b0;

        if (clr) begin
            state_nx   = IDLE;
            num_cnt_nx = '0;
            pos_cnt_nx = '0;
            frm_cnt_nx = '0;
        end else if (accept) begin
            if (at_last) begin
                num_cnt_nx = '0;
                pos_cnt_nx = '0;
                frm_cnt_nx = '0;
                done_nx    = 1'b1;
`ifdef FRAME_COUNTER_WRAP_EN
                state_nx   = RUN;
`else
                state_nx   = DONE;
`endif
            end else begin
                state_nx   = RUN;
                num_cnt_nx = num_cnt + NUM_W'(1);
                if (at_frame_end) begin
                    pos_cnt_nx = '0;
                    frm_cnt_nx = frm_cnt + FRM_W'(1);
                end else begin
                    pos_cnt_nx = pos_cnt + POS_W'(1);
                end
            end
        end else begin
`ifndef FRAME_COUNTER_WRAP_EN
            // Without wrap, done is a level that follows the DONE state.
            done_nx = (state == DONE);
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            num_cnt <= '0;
            pos_cnt <= '0;
            frm_cnt <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            num_cnt <= num_cnt_nx;
            pos_cnt <= pos_cnt_nx;
            frm_cnt <= frm_cnt_nx;
            done    <= done_nx;
        end
    end

    // Output tags carry the counter values before this sample's increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            do_en  <= 1'b0;
            data_o <= '0;
            num    <= '0;
            pos    <= '0;
            frame  <= '0;
            sof    <= 1'b0;
            eof    <= 1'b0;
            last   <= 1'b0;
        end else if (clr) begin
            do_en  <= 1'b0;
            data_o <= '0;
            num    <= '0;
            pos    <= '0;
            frame  <= '0;
            sof    <= 1'b0;
            eof    <= 1'b0;
            last   <= 1'b0;
        end else if (accept) begin
            do_en  <= 1'b1;
            data_o <= OUTPUTLENGTH'(data_i);
            num    <= num_cnt;
            pos    <= pos_cnt;
            frame  <= frm_cnt;
            sof    <= (pos_cnt == '0);
            eof    <= at_frame_end || at_last;
            last   <= at_last;
        end else begin
            do_en  <= 1'b0;
            sof    <= 1'b0;
            eof    <= 1'b0;
            last   <= 1'b0;
        end
    end

endmodule
